sha256_msg_feeder: RTL
======================

# sha256_msg_feeder

Drives the `sha256` compression core from a 32-bit message word stream. It accepts message words, assembles 512-bit blocks, and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It sequences `init`/`next_block` against the core's `ready`, then captures and holds the final 256-bit digest. It sits between the bus-side hash register interface and the `sha256` core instance.

## Interface
- `CNT_W`, default 32: width of the message byte counter. The length field is the counter zero-extended to 61 bits, shifted left by 3.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `msg_start`  in  1  begin a new message. Accepted only in IDLE with `sha_ready`=1.
- `in_valid`  in  1  a message word is offered.
- `in_ready`  out  1  feeder accepts a word. A word transfers when `in_valid` and `in_ready` are both 1.
- `in_data`  in  32  message word. `[31:24]` is the first byte.
- `in_last`  in  1  this word is the final word of the message.
- `in_bytes`  in  3  valid bytes in the final word, 0..4. Values above 4 are treated as 4. Ignored unless `in_last`=1.
- `sha_init`  out  1  to core `init`.
- `sha_next`  out  1  to core `next_block`.
- `sha_block`  out  512  to core `block_in`. Word 0 is at `[511:480]`.
- `sha_ready`  in  1  from core `ready`.
- `sha_hash`  in  256  from core `hash_out`.
- `digest`  out  256  final hash. Held until the next `msg_start`.
- `digest_valid`  out  1  `digest` holds a completed message's hash.
- `busy`  out  1  feeder is not in IDLE.
- `err`  out  1  byte-counter overflow flag (see Configuration).

## Operation
- Block buffer: 16×32 words, write index `widx` (0..16), byte counter `cnt`.
- Flags: `end_seen` (final word accepted), `pad80` (0x80 byte placed), `len_done` (length words written).
- States: IDLE, FILL, ISSUE, WAIT, PAD, DONE.
- IDLE → FILL on accepted `msg_start`:
  - assert `sha_init` for 1 cycle;
  - clear `widx`, `cnt`, all flags, `digest_valid`, `err`.
  - `msg_start` in any other state is ignored.
- FILL: `in_ready`=1.
  - Each accepted word is written to `buf[widx]`; `widx` increments.
  - Non-last word: `cnt += 4`.
  - Last word with n=`in_bytes`: `cnt += n`; bytes ≥ n are zeroed.
    - If n<4: byte n is set to 0x80 and `pad80` is set.
    - `end_seen` is set.
  - When `widx` reaches 16 → ISSUE.
  - On a last word with `widx`<16 → PAD.
- PAD: writes one word per cycle at `widx`; `in_ready`=0.
  - If `!pad80`: write 0x80000000 and set `pad80`.
  - Else if `widx`==14 and `!len_done`: write `len[63:32]`, then `len[31:0]` at index 15, and set `len_done`.
  - Else: write 0.
  - Length words are written only if 0x80 occupies an index ≤13. Otherwise zero-fill to 16, issue the block, and the next block is zeros plus length.
  - `widx`==16 → ISSUE.
- ISSUE: `sha_next`=1 for exactly 1 cycle, with `sha_block` = buffer contents. Next state is WAIT.
- WAIT: ignores `sha_ready` for 1 guard cycle, then waits for `sha_ready`=1. Then:
  - `len_done` → DONE;
  - else if `end_seen` → PAD with `widx`=0;
  - else → FILL with `widx`=0.
- DONE: `digest` ← `sha_hash`; `digest_valid`←1; → IDLE.
- Padding arithmetic: `len = {cnt,3'b000}` zero-extended to 64 bits.
  - `cnt` wraps modulo 2^CNT_W.
  - A message of k full words ending with `in_bytes`=4 places 0x80 at word index k mod 16.

## Timing
- Reset values:
  - `in_ready`, `sha_init`, `sha_next`, `digest_valid`, `busy`, `err` are 0;
  - `digest` and `sha_block` are 0;
  - state is IDLE.
- Reset mid-message aborts the message. The core is not reset by the feeder; the next `msg_start` waits for `sha_ready` and reinitialises the core via `sha_init`.
- `sha_init` is registered: high in the cycle after `msg_start` is sampled.
- Each block costs 1 cycle (ISSUE) + 1 guard cycle + the core's latency (66 cycles from `next_block` to `ready`).
- Padding costs 1 cycle per padded word.
- `digest_valid` rises 1 cycle after the final `sha_ready` is seen (DONE), and stays high until the next accepted `msg_start`.
- `in_ready` drops in the cycle after the 16th word or the last word is accepted. Backpressure never loses or duplicates a word.

## Configuration
- `SHA256_FEEDER_OVF_CHECK_EN` defined:
  - `err` is set (sticky) when a `cnt` increment carries out of CNT_W bits;
  - the message still completes using the wrapped length;
  - `err` clears on `msg_start` or reset.
- Undefined: `err` is tied to 0 and no carry logic is built.

## Test plan
- "abc": `msg_start`, then word 0x61626300 with `in_last`=1, `in_bytes`=3 →
  - single `sha_next` with `sha_block` = 61626380, 13 zero words, 00000000, 00000018;
  - `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: 1 word with `in_last`=1, `in_bytes`=0 →
  - block = 80000000, zeros, length 0;
  - `digest` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 14 words, last `in_bytes`=4 →
  - two `sha_next` pulses; the second block is 80000000 at index 0 and length 000001C0;
  - `digest` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: random `in_valid` gaps plus a 64-byte message →
  - exactly 2 blocks; block 1 equals the input words;
  - block 2 = 80000000, zeros, length 00000200.
- `msg_start` pulsed during WAIT, and `rst_n` low for 1 cycle mid-FILL →
  - the `msg_start` during WAIT is ignored;
  - after the reset: `busy`=0 and `digest_valid`=0;
  - a following "abc" run yields the correct digest.
- With the macro and `CNT_W`=4: a 20-byte message sets `err`=1 and the length field equals 4×8=0x20.

Source files
------------

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: packs 32-bit words into 512-bit blocks, applies FIPS 180-4 padding and
// sequences the compression core. Define SHA256_FEEDER_OVF_CHECK_EN to build the byte-counter overflow flag.
module sha256_msg_feeder #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         sha_init,
  output logic         sha_next,
  output logic [511:0] sha_block,
  input  logic         sha_ready,
  input  logic [255:0] sha_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_PAD,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        blk_buf [16];
  logic [4:0]         widx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_add;
  logic [CNT_W-1:0]   cnt_next;
  logic               end_seen;
  logic               pad80;
  logic               len_done;
  logic               guard;
  logic [63:0]        len;
  logic [2:0]         nbytes;
  logic               word_fire;
  logic               start_ok;
  logic               buf_we;
  logic [31:0]        buf_wd;

  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  // Keep the first n bytes, put the 0x80 terminator in byte n, zero the rest.
  function automatic logic [31:0] pad_last_word(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {w[31:24], 24'h80_0000};
      3'd2:    return {w[31:16], 16'h8000};
      3'd3:    return {w[31:8], 8'h80};
      default: return w;
    endcase
  endfunction

  assign nbytes    = clamp_bytes(in_bytes);
  assign cnt_add   = in_last ? CNT_W'(nbytes) : CNT_W'(3'd4);
  assign word_fire = (state == S_FILL) && in_valid && in_ready;
  assign start_ok  = (state == S_IDLE) && msg_start && sha_ready;
  assign len       = 64'(cnt) << 3;

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign sha_block[511-32*g -: 32] = blk_buf[g];
  end

`ifdef SHA256_FEEDER_OVF_CHECK_EN
  logic cnt_carry;
  assign {cnt_carry, cnt_next} = {1'b0, cnt} + {1'b0, cnt_add};

  always_ff @(posedge clk) begin
    if (!rst_n)                      err <= 1'b0;
    else if (start_ok)               err <= 1'b0;
    else if (word_fire && cnt_carry) err <= 1'b1;
  end
`else
  assign cnt_next = cnt + cnt_add;
  assign err      = 1'b0;
`endif

  // Buffer write port: message words in FILL, terminator/zero/length words in PAD.
  always_comb begin
    buf_we = 1'b0;
    buf_wd = 32'h0;
    if (word_fire) begin
      buf_we = 1'b1;
      buf_wd = in_last ? pad_last_word(in_data, nbytes) : in_data;
    end else if (state == S_PAD) begin
      buf_we = 1'b1;
      if (!pad80)                          buf_wd = 32'h8000_0000;
      else if (widx == 5'd14 && !len_done) buf_wd = len[63:32];
      else if (widx == 5'd15 && len_done)  buf_wd = len[31:0];
      else                                 buf_wd = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) blk_buf[i] <= 32'h0;
    end else if (buf_we) begin
      blk_buf[widx[3:0]] <= buf_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      sha_init     <= 1'b0;
      sha_next     <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
      widx         <= 5'd0;
      cnt          <= '0;
      end_seen     <= 1'b0;
      pad80        <= 1'b0;
      len_done     <= 1'b0;
      guard        <= 1'b0;
    end else begin
      sha_init <= 1'b0;
      sha_next <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            sha_init     <= 1'b1;
            widx         <= 5'd0;
            cnt          <= '0;
            end_seen     <= 1'b0;
            pad80        <= 1'b0;
            len_done     <= 1'b0;
            digest_valid <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (word_fire) begin
            widx <= widx + 5'd1;
            cnt  <= cnt_next;
            if (in_last) begin
              end_seen <= 1'b1;
              if (nbytes != 3'd4) pad80 <= 1'b1;
            end
            if (widx == 5'd15) begin
              in_ready <= 1'b0;
              sha_next <= 1'b1;
              state    <= S_ISSUE;
            end else if (in_last) begin
              in_ready <= 1'b0;
              state    <= S_PAD;
            end
          end
        end
        S_PAD: begin
          widx <= widx + 5'd1;
          if (!pad80)                          pad80    <= 1'b1;
          else if (widx == 5'd14 && !len_done) len_done <= 1'b1;
          if (widx == 5'd15) begin
            sha_next <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          guard <= 1'b1;
          state <= S_WAIT;
        end
        // The core may still show ready in the cycle after next_block, so skip one cycle.
        S_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (sha_ready) begin
            if (len_done) begin
              state <= S_DONE;
            end else if (end_seen) begin
              widx  <= 5'd0;
              state <= S_PAD;
            end else begin
              widx     <= 5'd0;
              in_ready <= 1'b1;
              state    <= S_FILL;
            end
          end
        end
        S_DONE: begin
          digest       <= sha_hash;
          digest_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
